// File: rtl/issue_ctrl_pkg.sv
// Shared decode definitions for the issue controller: RV64IM opcode map,
// instruction field extraction and the per-opcode operand-use summary.
package issue_ctrl_pkg;

   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      USE_NONE    = 2'd0,
      USE_RS1     = 2'd1,
      USE_RS1_RS2 = 2'd2
   } opnd_use_e;

   typedef struct packed {
      opnd_use_e opnd;
      logic      writes_rd;
      logic      long_lat;
      logic      illegal;
   } dec_t;

   function automatic logic [6:0] f_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] instr);
      return instr[11:7];
   endfunction

   function automatic logic [4:0] f_rs1(input logic [31:0] instr);
      return instr[19:15];
   endfunction

   function automatic logic [4:0] f_rs2(input logic [31:0] instr);
      return instr[24:20];
   endfunction

   function automatic logic [6:0] f_funct7(input logic [31:0] instr);
      return instr[31:25];
   endfunction

   function automatic dec_t decode(input logic [31:0] instr);
      dec_t d;
      d.opnd      = USE_NONE;
      d.writes_rd = 1'b0;
      d.long_lat  = 1'b0;
      d.illegal   = 1'b0;
      case (f_opcode(instr))
         OP, OP_32: begin
            d.opnd      = USE_RS1_RS2;
            d.writes_rd = 1'b1;
            d.long_lat  = (f_funct7(instr) == FUNCT7_MULDIV);
         end
         STORE, BRANCH: begin
            d.opnd      = USE_RS1_RS2;
         end
         OP_IMM, OP_IMM_32, JALR: begin
            d.opnd      = USE_RS1;
            d.writes_rd = 1'b1;
         end
         LOAD: begin
            d.opnd      = USE_RS1;
            d.writes_rd = 1'b1;
            d.long_lat  = 1'b1;
         end
         LUI, AUIPC, JAL: begin
            d.writes_rd = 1'b1;
         end
         default: begin
            d.illegal   = 1'b1;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-register scoreboard for long-latency producers; a set and a clear of
// the same register in one cycle leaves it busy. x0 can never become busy.
module issue_scoreboard
   import issue_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        set_en,
   input  logic [4:0]  set_rd,
   input  logic        clr_en,
   input  logic [4:0]  clr_rd,
   output logic [31:0] busy
);

   logic [31:0] busy_r;
   logic [31:0] set_mask_s;
   logic [31:0] clr_mask_s;
   logic [31:0] busy_nxt_s;

   // next busy vector: clear first, then set so the set has priority
   always_comb begin
      set_mask_s = (set_en && (set_rd != 5'd0)) ? (32'd1 << set_rd) : 32'd0;
      clr_mask_s = (clr_en && (clr_rd != 5'd0)) ? (32'd1 << clr_rd) : 32'd0;
      busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
   end

   // busy register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign busy = busy_r;

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: one-entry decode slot, busy-scoreboard hazard
// check against long-latency producers, and a registered issue stage.
module issue_ctrl
   import issue_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_instr,
   input  logic [63:0] fetch_pc,
   output logic        fetch_ready,
   output logic        iss_valid,
   output logic [31:0] iss_instr,
   output logic [63:0] iss_pc,
   output logic        iss_illegal,
   input  logic        iss_ready,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        flush,
   output logic [31:0] busy,
   output logic [15:0] stall_cycles
);

   logic        slot_valid_r;
   logic [31:0] slot_instr_r;
   logic [63:0] slot_pc_r;
   logic        iss_valid_r;
   logic [31:0] iss_instr_r;
   logic [63:0] iss_pc_r;
   logic        iss_illegal_r;
   logic [15:0] stall_r;

   dec_t        dec_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [4:0]  rd_s;
   logic        hazard_s;
   logic        slot_move_s;
   logic        fetch_fire_s;
   logic        set_en_s;

   // decode the slot and check it against the registered busy vector (no bypass)
   always_comb begin
      dec_s        = decode(slot_instr_r);
      rs1_s        = f_rs1(slot_instr_r);
      rs2_s        = f_rs2(slot_instr_r);
      rd_s         = f_rd(slot_instr_r);
      hazard_s     = ((dec_s.opnd != USE_NONE) && busy[rs1_s]) ||
                     ((dec_s.opnd == USE_RS1_RS2) && busy[rs2_s]) ||
                     (dec_s.writes_rd && busy[rd_s]);
      slot_move_s  = slot_valid_r && !hazard_s && (!iss_valid_r || iss_ready) && !flush;
      fetch_ready  = !flush && (!slot_valid_r || slot_move_s);
      fetch_fire_s = fetch_valid && fetch_ready;
      set_en_s     = slot_move_s && dec_s.long_lat;
   end

   issue_scoreboard u_scoreboard (
      .clk    (clk),
      .rst    (rst),
      .set_en (set_en_s),
      .set_rd (rd_s),
      .clr_en (wb_valid),
      .clr_rd (wb_rd),
      .busy   (busy)
   );

   // decode slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid_r <= 1'b0;
         slot_instr_r <= 32'd0;
         slot_pc_r    <= 64'd0;
      end else if (flush) begin
         slot_valid_r <= 1'b0;
      end else if (fetch_fire_s) begin
         slot_valid_r <= 1'b1;
         slot_instr_r <= fetch_instr;
         slot_pc_r    <= fetch_pc;
      end else if (slot_move_s) begin
         slot_valid_r <= 1'b0;
      end else begin
         slot_valid_r <= slot_valid_r;
      end
   end

   // issue register: payload only changes on a slot move, so it holds under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_valid_r   <= 1'b0;
         iss_instr_r   <= 32'd0;
         iss_pc_r      <= 64'd0;
         iss_illegal_r <= 1'b0;
      end else if (flush) begin
         iss_valid_r   <= 1'b0;
      end else if (slot_move_s) begin
         iss_valid_r   <= 1'b1;
         iss_instr_r   <= slot_instr_r;
         iss_pc_r      <= slot_pc_r;
         iss_illegal_r <= dec_s.illegal;
      end else if (iss_ready) begin
         iss_valid_r   <= 1'b0;
      end else begin
         iss_valid_r   <= iss_valid_r;
      end
   end

   // saturating hazard-stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_r <= 16'd0;
      end else if (slot_valid_r && hazard_s && !flush && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'd1;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign iss_valid    = iss_valid_r;
   assign iss_instr    = iss_instr_r;
   assign iss_pc       = iss_pc_r;
   assign iss_illegal  = iss_illegal_r;
   assign stall_cycles = stall_r;

endmodule
